// File: rtl/bec_la_sequencer.sv
// Initiator for the BEC logic-analyzer slave: loads seven GF(2^163) operands
// as 14 half-operand chunks, triggers processing, reads four 82-bit result
// words and releases the core back to idle.
//
// Ports:
//   wb_clk_i, wb_rst_n        clock (rising edge), async active-low reset
//   op_we, op_idx, op_data    operand RAM write port (idx 0..6 = A,B,C,D,E,F,H)
//   start                     begin one transaction (accepted in IDLE only)
//   la_status                 slave's la_data_out
//   la_frame, la_oenb         slave's la_data_in / la_oenb (0 = driving)
//   busy, done, err           transaction status (err is sticky until start)
//   res_valid, res_idx,       one-cycle result strobe, word index and the
//   res_data                  captured la_status[113:32]
module bec_la_sequencer #(
  parameter int unsigned TIMEOUT = 4096,
  parameter logic [31:0] CTRL_HI = 32'h0000_0001
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_n,
  input  logic         op_we,
  input  logic [2:0]   op_idx,
  input  logic [162:0] op_data,
  input  logic         start,
  input  logic [127:0] la_status,
  output logic [127:0] la_frame,
  output logic [127:0] la_oenb,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         res_valid,
  output logic [1:0]   res_idx,
  output logic [81:0]  res_data
);

  localparam int unsigned OP_W    = 163;
  localparam int unsigned HALF_W  = 82;
  localparam int unsigned FRAME_W = 128;
  localparam int unsigned THERM_W = 14;
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CMD_WR   = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_CMD_PROC = 3'd3;
  localparam logic [2:0] S_READ     = 3'd4;
  localparam logic [2:0] S_RELEASE  = 3'd5;

  localparam logic [3:0]  LAST_CHUNK  = 4'd13;
  localparam logic [5:0]  ST_IDLE     = 6'b010000;
  localparam logic [5:0]  ST_LOADED   = 6'b011110;
  localparam logic [5:0]  ST_PROC     = 6'b100111;
  localparam logic [13:0] TAG_ABORT   = 14'b00110000000000;

  logic [OP_W-1:0] op_ram [7];

  logic [2:0]       state_q, state_n;
  logic [3:0]       k_q, k_n;
  logic [1:0]       r_q, r_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             err_evt_q, err_evt_n;
  logic             busy_n, done_n, err_n, res_valid_n;
  logic [1:0]       res_idx_n;
  logic [HALF_W-1:0] res_data_n;
  logic [FRAME_W-1:0] frame_n, oenb_n;
  logic [OP_W-1:0]  chunk_op;
  logic             ack, abort, fail;
  logic             status_unused;

  // Command field [31:0] of la_status is never consulted.
  assign status_unused = ^la_status[31:0];

  // Expected read-back tag for result word r.
  function automatic logic [13:0] read_tag(input logic [1:0] r);
    logic [13:0] t;
    case (r)
      2'd0:    t = 14'b11000100000000;
      2'd1:    t = 14'b11001000000000;
      2'd2:    t = 14'b11001100000000;
      default: t = 14'b11010000000000;
    endcase
    return t;
  endfunction

  // Frame driven while sitting in state st with chunk k / word r.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [2:0] st,
                                                     input logic [3:0] k,
                                                     input logic [1:0] r,
                                                     input logic [OP_W-1:0] op);
    logic [THERM_W-1:0] therm;
    logic [HALF_W-1:0]  payload;
    logic [FRAME_W-1:0] f;
    therm = '0;
    for (int i = 0; i < int'(THERM_W); i++) therm[i] = (i <= int'(k));
    // Even chunks carry the upper 81 bits, odd chunks the lower 82.
    payload = k[0] ? op[HALF_W-1:0] : {1'b0, op[OP_W-1:HALF_W]};
    case (st)
      S_CMD_WR:   f = {CTRL_HI, 64'h0, 32'hAB40_0000};
      S_LOAD:     f = {CTRL_HI, therm, payload};
      S_CMD_PROC: f = {CTRL_HI, 64'h0, 32'hAB41_0000};
      S_READ:     f = {CTRL_HI, 64'h0, 8'hAB, 4'h0, r, 2'b00, 16'h0};
      S_RELEASE:  f = {CTRL_HI, 64'h0, 32'hAB50_0000};
      default:    f = '0;
    endcase
    return f;
  endfunction

  // Operand RAM: writable only between transactions, never reset.
  always_ff @(posedge wb_clk_i) begin
    if (op_we && !busy && (op_idx != 3'd7)) op_ram[op_idx] <= op_data;
  end

  // Acknowledge / abort decode for the current state.
  always_comb begin
    ack   = 1'b0;
    abort = 1'b0;
    case (state_q)
      S_CMD_WR:   ack = (la_status[125:122] == 4'b0000) && (la_status[127:122] != ST_IDLE);
      S_LOAD:     ack = (k_q == LAST_CHUNK) ? (la_status[127:122] == ST_LOADED)
                                            : (la_status[125:122] == (k_q + 4'd1));
      S_CMD_PROC: ack = (la_status[127:122] == ST_PROC);
      S_READ: begin
        ack   = (la_status[127:114] == read_tag(r_q));
        abort = (la_status[127:114] == TAG_ABORT);
      end
      S_RELEASE:  ack = (la_status[127:122] == ST_IDLE);
      default:    ack = 1'b0;
    endcase
  end

  // Next-state, wait counter and registered-output computation.
  always_comb begin
    state_n     = state_q;
    k_n         = k_q;
    r_n         = r_q;
    cnt_n       = cnt_q;
    busy_n      = busy;
    err_n       = err;
    err_evt_n   = 1'b0;
    done_n      = 1'b0;
    res_valid_n = 1'b0;
    res_idx_n   = res_idx;
    res_data_n  = res_data;
    fail        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Holding off one cycle after done/err keeps those events distinct
        // from a start acceptance.
        if (start && !done && !err_evt_q) begin
          state_n = S_CMD_WR;
          busy_n  = 1'b1;
          err_n   = 1'b0;
        end
      end
      S_CMD_WR: begin
        if (ack) begin
          state_n = S_LOAD;
          k_n     = 4'd0;
        end
      end
      S_LOAD: begin
        if (ack) begin
          if (k_q == LAST_CHUNK) state_n = S_CMD_PROC;
          else                   k_n     = k_q + 4'd1;
        end
      end
      S_CMD_PROC: begin
        if (ack) begin
          state_n = S_READ;
          r_n     = 2'd0;
        end
      end
      S_READ: begin
        if (abort) begin
          fail = 1'b1;
        end else if (ack) begin
          res_valid_n = 1'b1;
          res_idx_n   = r_q;
          res_data_n  = la_status[113:32];
          if (r_q == 2'd3) state_n = S_RELEASE;
          else             r_n     = r_q + 2'd1;
        end
      end
      S_RELEASE: begin
        if (ack) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Per-wait counter: any advance reloads it, a full budget aborts.
    if (state_q != S_IDLE) begin
      if (ack && !abort)                         cnt_n = '0;
      else if (cnt_q == CNT_W'(TIMEOUT - 1))     fail  = 1'b1;
      else                                       cnt_n = cnt_q + CNT_W'(1);
    end else begin
      cnt_n = '0;
    end

    if (fail) begin
      state_n     = S_IDLE;
      busy_n      = 1'b0;
      err_n       = 1'b1;
      err_evt_n   = 1'b1;
      res_valid_n = 1'b0;
      cnt_n       = '0;
    end

    chunk_op = op_ram[k_n[3:1]];
    frame_n  = build_frame(state_n, k_n, r_n, chunk_op);
    oenb_n   = busy_n ? '0 : '1;
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      err_evt_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
      la_frame  <= '0;
      la_oenb   <= '1;
    end else begin
      state_q   <= state_n;
      k_q       <= k_n;
      r_q       <= r_n;
      cnt_q     <= cnt_n;
      err_evt_q <= err_evt_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
      res_valid <= res_valid_n;
      res_idx   <= res_idx_n;
      res_data  <= res_data_n;
      la_frame  <= frame_n;
      la_oenb   <= oenb_n;
    end
  end

endmodule

// File: tb/tb_bec_la_sequencer.sv
// Randomized scoreboard bench for bec_la_sequencer with a behavioural LA slave.
module tb_bec_la_sequencer;

  localparam int unsigned TIMEOUT = 4096;
  localparam logic [31:0] CTRL_HI = 32'h0000_0001;
  localparam logic [127:0] NEUTRAL = {6'b111111, 122'd0};
  localparam logic [127:0] ONES    = {128{1'b1}};

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_n = 1'b0;
  logic         op_we = 1'b0;
  logic [2:0]   op_idx = 3'd0;
  logic [162:0] op_data = '0;
  logic         start = 1'b0;
  logic [127:0] la_status = '0;
  logic [127:0] la_frame, la_oenb;
  logic         busy, done, err, res_valid;
  logic [1:0]   res_idx;
  logic [81:0]  res_data;

  always #5 wb_clk_i = ~wb_clk_i;

  bec_la_sequencer #(.TIMEOUT(TIMEOUT), .CTRL_HI(CTRL_HI)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .op_we(op_we), .op_idx(op_idx),
    .op_data(op_data), .start(start), .la_status(la_status), .la_frame(la_frame),
    .la_oenb(la_oenb), .busy(busy), .done(done), .err(err), .res_valid(res_valid),
    .res_idx(res_idx), .res_data(res_data)
  );

  typedef struct { int kind; int idx; logic [81:0] data; } exp_t;  // kind 0=res 1=done 2=err
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  logic [162:0] model_op [7];
  logic [81:0]  slave_res [4];
  logic [13:0]  tag_tbl [4] = '{14'b11000100000000, 14'b11001000000000,
                                14'b11001100000000, 14'b11010000000000};
  int  withhold_k = -1;
  int  abort_r = -1;
  int  stall_pct = 25;
  bit  expect_timeout = 1'b0;
  longint cyc = 0;
  longint t7 = 0;
  logic [127:0] prev_frame = '0;
  logic err_prev = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [162:0] rand163();
    return 163'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  function automatic logic [81:0] rand82();
    return 82'({$urandom, $urandom, $urandom});
  endfunction

  // Reference chunk frame: k+1 low ones in the slot code, half operand k/2.
  function automatic logic [127:0] exp_chunk_frame(input int k);
    logic [14:0] t;
    logic [162:0] op;
    logic [81:0] p;
    t  = 15'((1 << (k + 1)) - 1);
    op = model_op[k / 2];
    if (k % 2 == 0) p = {1'b0, op[162:82]};
    else            p = op[81:0];
    return {CTRL_HI, t[13:0], p};
  endfunction

  // Behavioural slave: status word the slave presents for a given frame.
  function automatic logic [127:0] slave_resp(input logic [127:0] f);
    logic [127:0] s;
    logic [13:0] th;
    logic [7:0] sel;
    int k, r;
    s  = '0;
    th = f[95:82];
    if (f == '0) begin
      s[127:122] = 6'b010000;
    end else if (th != 14'd0) begin
      k = $countones(th) - 1;
      if (k == withhold_k)  s = NEUTRAL;
      else if (k < 13)      s[125:122] = 4'(k + 1);
      else                  s[127:122] = 6'b011110;
    end else if (f[31:0] == 32'hAB40_0000) begin
      s = '0;
    end else if (f[31:0] == 32'hAB41_0000) begin
      s[127:122] = 6'b100111;
    end else if (f[31:0] == 32'hAB50_0000) begin
      s[127:122] = 6'b010000;
    end else if (f[31:24] == 8'hAB && f[15:0] == 16'h0) begin
      sel = f[23:16];
      r = int'(sel) / 4;
      if (int'(sel) % 4 == 0 && r < 4) begin
        if (r == abort_r) s[127:114] = 14'b00110000000000;
        else begin
          s[127:114] = tag_tbl[r];
          s[113:32]  = slave_res[r];
        end
      end else s = NEUTRAL;
    end else begin
      s = NEUTRAL;
    end
    return s;
  endfunction

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // Slave drives its status on the falling edge, with random stalls.
  always @(negedge wb_clk_i) begin
    if ($urandom_range(99) < stall_pct) la_status = NEUTRAL;
    else                                la_status = slave_resp(la_frame);
  end

  // Monitor: checks chunk frames and pops the scoreboard on DUT events.
  always @(negedge wb_clk_i) begin
    exp_t e;
    int k;
    if (!wb_rst_n) begin
      prev_frame = '0;
      err_prev   = 1'b0;
    end else begin
      if (la_frame != prev_frame && la_frame[95:82] != 14'd0) begin
        k = $countones(la_frame[95:82]) - 1;
        chk($sformatf("chunk%0d_frame", k), la_frame, exp_chunk_frame(k));
        if (k == 7) t7 = cyc;
      end
      prev_frame = la_frame;
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL res_unexpected actual idx=%0d required=none", res_idx);
        end else begin
          e = exp_q.pop_front();
          chk("res_kind", 128'(res_valid ? 0 : 1), 128'(e.kind));
          chk("res_idx", 128'(res_idx), 128'(e.idx));
          chk("res_data", 128'(res_data), 128'(e.data));
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("done_kind", 128'(1), 128'(e.kind));
        end
      end
      if (err && !err_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL err_unexpected actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("err_kind", 128'(2), 128'(e.kind));
        end
        chk("err_busy", 128'(busy), 128'(0));
        chk("err_oenb", la_oenb, ONES);
        chk("err_frame", la_frame, '0);
        if (expect_timeout) chk("timeout_latency", 128'(cyc - t7), 128'(TIMEOUT));
      end
      err_prev = err;
    end
  end

  task automatic write_op(input int idx, input logic [162:0] v);
    @(negedge wb_clk_i);
    op_we = 1'b1; op_idx = 3'(idx); op_data = v;
    @(negedge wb_clk_i);
    op_we = 1'b0;
    if (idx < 7) model_op[idx] = v;
  endtask

  task automatic push_expect();
    exp_t e;
    for (int r = 0; r < 4; r++) slave_res[r] = rand82();
    if (withhold_k >= 0) begin
      e.kind = 2; e.idx = 0; e.data = '0; exp_q.push_back(e);
    end else begin
      for (int r = 0; r < 4; r++) begin
        if (abort_r >= 0 && r >= abort_r) break;
        e.kind = 0; e.idx = r; e.data = slave_res[r]; exp_q.push_back(e);
      end
      e.kind = (abort_r >= 0) ? 2 : 1; e.idx = 0; e.data = '0; exp_q.push_back(e);
    end
  endtask

  // mode 0 plain, 1 = op_we on A while busy, 2 = start with op_we on A.
  task automatic run_txn(input int mode);
    int n;
    logic [162:0] v;
    push_expect();
    @(negedge wb_clk_i);
    start = 1'b1;
    if (mode == 2) begin
      v = rand163();
      op_we = 1'b1; op_idx = 3'd0; op_data = v;
      model_op[0] = v;
    end
    @(negedge wb_clk_i);
    start = 1'b0; op_we = 1'b0;
    chk("start_busy", 128'(busy), 128'(1));
    chk("start_oenb", la_oenb, '0);
    if (mode == 1) begin
      op_we = 1'b1; op_idx = 3'd0; op_data = rand163();
      @(negedge wb_clk_i);
      op_we = 1'b0;
    end
    n = 0;
    while (busy && n < 3 * TIMEOUT) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL txn_bound actual=busy required=idle");
      wb_rst_n = 1'b0;
      exp_q.delete();
      @(negedge wb_clk_i);
      wb_rst_n = 1'b1;
    end
    chk("idle_oenb", la_oenb, ONES);
    chk("idle_frame", la_frame, '0);
    @(negedge wb_clk_i);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #23;
    chk("rst_frame", la_frame, '0);
    chk("rst_oenb", la_oenb, ONES);
    chk("rst_flags", {124'd0, busy, done, err, res_valid}, '0);
    chk("rst_res", {44'd0, res_idx, res_data}, '0);
    @(negedge wb_clk_i);
    wb_rst_n = 1'b1;

    for (int i = 0; i < 7; i++) write_op(i, rand163());
    write_op(0, 163'h1);
    write_op(6, {163{1'b1}});
    write_op(7, rand163());
    run_txn(0);

    run_txn(1);
    run_txn(0);
    run_txn(2);

    withhold_k = 7; expect_timeout = 1'b1;
    run_txn(0);
    withhold_k = -1; expect_timeout = 1'b0;
    chk("timeout_err_sticky", 128'(err), 128'(1));

    abort_r = 1;
    run_txn(0);
    abort_r = -1;

    // Reset in the middle of chunk 5.
    @(negedge wb_clk_i);
    start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    n = 0;
    while (la_frame[95:82] != 14'h003F && n < 2000) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("reach_chunk5", 128'(la_frame[95:82]), 128'(14'h003F));
    #2 wb_rst_n = 1'b0;
    #1;
    chk("midrst_oenb", la_oenb, ONES);
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_frame", la_frame, '0);
    exp_q.delete();
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    #2 wb_rst_n = 1'b1;
    run_txn(0);

    for (int t = 0; t < 4; t++) begin
      for (int w = 0; w < 3; w++) write_op(int'($urandom_range(7)), rand163());
      stall_pct = int'($urandom_range(60));
      run_txn(0);
    end

    repeat (3) @(negedge wb_clk_i);
    chk("queue_empty", 128'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
